// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the AXI-lite load/store unit:
//   lsu_op_e     - request opcode (NONE / LOAD / STORE)
//   lsu_cause_e  - completion status reported with each result
//   lsu_state_e  - master FSM states
//   AXI_RESP_OKAY, and size-to-mask helpers for alignment and byte strobes.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_OP_NONE  = 2'b00,
        LSU_OP_LOAD  = 2'b01,
        LSU_OP_STORE = 2'b10
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_CAUSE_OK           = 2'b00,
        LSU_CAUSE_MISALIGN     = 2'b01,
        LSU_CAUSE_ILLEGAL_SIZE = 2'b10,
        LSU_CAUSE_BUS          = 2'b11
    } lsu_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Low address bits that must be zero for an access of 1<<size bytes.
    function automatic logic [2:0] size_to_amask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            2'd3:    return 3'b111;
            default: return 3'b111;
        endcase
    endfunction

    // Right-aligned byte-enable pattern for an access of 1<<size bytes.
    function automatic logic [7:0] size_to_strb(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            2'd3:    return 8'hFF;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for one access.
//   addr_i/size_i    - byte address and log2 byte count
//   unsigned_i       - zero-extend loads instead of sign-extend
//   wdata_i/rdata_i  - right-aligned store data / raw bus read data
//   misalign_o       - address not naturally aligned to size
//   addr_o           - address aligned down to size
//   wstrb_o/wdata_o  - byte strobes and store data shifted onto their lanes
//   rdata_o          - load data extracted from its lanes and extended
// Lane offset is taken from the aligned address, so a force-aligned access
// uses the same lanes it is issued on.
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   addr_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic              misalign_o,
    output logic [XLEN-1:0]   addr_o,
    output logic [XLEN/8-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o
);

    localparam int unsigned STRBW = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(STRBW);

    logic [2:0]      amask_s;
    logic [OFFW-1:0] off_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] one_s;
    logic [XLEN-1:0] keep_s;
    logic [6:0]      nbits_s;
    logic            sign_s;

    assign amask_s    = size_to_amask(size_i);
    assign misalign_o = |(addr_i[2:0] & amask_s);
    assign addr_o     = addr_i & ~{{(XLEN-3){1'b0}}, amask_s};
    assign off_s      = addr_o[OFFW-1:0];

    assign wstrb_o = STRBW'(size_to_strb(size_i)) << off_s;
    assign wdata_o = wdata_i << {off_s, 3'b000};

    // keep_s masks the loaded bytes; shifting by a full XLEN wraps to all-ones,
    // which covers the full-width access without a special case.
    assign shifted_s = rdata_i >> {off_s, 3'b000};
    assign nbits_s   = 7'd8 << size_i;
    assign one_s     = {{(XLEN-1){1'b0}}, 1'b1};
    assign keep_s    = (one_s << nbits_s) - one_s;
    // keep_s ^ (keep_s >> 1) isolates the top loaded bit, i.e. the sign bit.
    assign sign_s    = ~unsigned_i & (|(shifted_s & (keep_s ^ (keep_s >> 1'b1))));
    assign rdata_o   = (shifted_s & keep_s) | ({XLEN{sign_s}} & ~keep_s);

endmodule

// File: rtl/lsu_axi.sv
// -----------------------------------------------------------------------------
// lsu_axi
// Registered load/store unit with an AXI-lite master, one access in flight.
//   clk/rst              - clock, synchronous active-high reset
//   in_*                 - request from EX (valid/ready)
//   out_*                - result to WB (valid/ready), data, error and cause
//   ar*/r*/aw*/w*/b*     - AXI-lite master channels
// Faulting (misaligned / illegal size) and NONE requests complete without bus
// traffic. AXI outputs come only from the request register and state.
// -----------------------------------------------------------------------------
module lsu_axi
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned AXI_ADDR_W    = 32,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [XLEN-1:0]       in_addr,
    input  logic [XLEN-1:0]       in_wdata,
    input  logic [XLEN-1:0]       in_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic                  out_err,
    output logic [1:0]            out_cause,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [XLEN-1:0]       rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [AXI_ADDR_W-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [XLEN-1:0]       wdata,
    output logic [XLEN/8-1:0]     wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int unsigned STRBW   = XLEN / 8;
    localparam bit          SIZE3_OK = (XLEN == 64);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [STRBW-1:0]  wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    lsu_cause_e        out_cause_q, out_cause_d;

    logic              idle_s;
    logic [XLEN-1:0]   al_addr_in_s;
    logic [1:0]        al_size_in_s;
    logic              al_uns_in_s;
    logic              al_misalign_s;
    logic [XLEN-1:0]   al_addr_s;
    logic [STRBW-1:0]  al_wstrb_s;
    logic [XLEN-1:0]   al_wdata_s;
    logic [XLEN-1:0]   al_rdata_s;
    logic              mem_op_s;
    logic              illegal_s;
    logic              trap_s;

    // In IDLE the aligner evaluates the incoming request (fault check and
    // lane shifting for capture); afterwards it serves the held request.
    assign idle_s       = (state_q == ST_IDLE);
    assign al_addr_in_s = idle_s ? in_addr     : addr_q;
    assign al_size_in_s = idle_s ? in_size     : size_q;
    assign al_uns_in_s  = idle_s ? in_unsigned : uns_q;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .addr_i     (al_addr_in_s),
        .size_i     (al_size_in_s),
        .unsigned_i (al_uns_in_s),
        .wdata_i    (in_wdata),
        .rdata_i    (rdata),
        .misalign_o (al_misalign_s),
        .addr_o     (al_addr_s),
        .wstrb_o    (al_wstrb_s),
        .wdata_o    (al_wdata_s),
        .rdata_o    (al_rdata_s)
    );

    assign mem_op_s  = (in_op == LSU_OP_LOAD) || (in_op == LSU_OP_STORE);
    assign illegal_s = (in_size == 2'd3) && !SIZE3_OK;
    assign trap_s    = al_misalign_s && MISALIGN_TRAP;

    // Next-state and register-update logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_cause_d = out_cause_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    size_d      = in_size;
                    uns_d       = in_unsigned;
                    addr_d      = al_addr_s;
                    wdata_d     = al_wdata_s;
                    wstrb_d     = al_wstrb_s;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    out_data_d  = {XLEN{1'b0}};
                    out_err_d   = 1'b0;
                    out_cause_d = LSU_CAUSE_OK;
                    if (!mem_op_s) begin
                        out_data_d = in_wb_data;
                        state_d    = ST_DONE;
                    end else if (illegal_s) begin
                        out_err_d   = 1'b1;
                        out_cause_d = LSU_CAUSE_ILLEGAL_SIZE;
                        state_d     = ST_DONE;
                    end else if (trap_s) begin
                        out_err_d   = 1'b1;
                        out_cause_d = LSU_CAUSE_MISALIGN;
                        state_d     = ST_DONE;
                    end else if (in_op == LSU_OP_LOAD) begin
                        state_d = ST_AR;
                    end else begin
                        state_d = ST_AW_W;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d = ST_R;
                end else begin
                    state_d = ST_AR;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    out_data_d = al_rdata_s;
                    if (rresp != AXI_RESP_OKAY) begin
                        out_err_d   = 1'b1;
                        out_cause_d = LSU_CAUSE_BUS;
                    end else begin
                        out_err_d   = 1'b0;
                        out_cause_d = LSU_CAUSE_OK;
                    end
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_R;
                end
            end
            ST_AW_W: begin
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_B;
                end else begin
                    state_d = ST_AW_W;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    out_data_d = {XLEN{1'b0}};
                    if (bresp != AXI_RESP_OKAY) begin
                        out_err_d   = 1'b1;
                        out_cause_d = LSU_CAUSE_BUS;
                    end else begin
                        out_err_d   = 1'b0;
                        out_cause_d = LSU_CAUSE_OK;
                    end
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_B;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_q      <= {XLEN{1'b0}};
            wdata_q     <= {XLEN{1'b0}};
            wstrb_q     <= {STRBW{1'b0}};
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            out_data_q  <= {XLEN{1'b0}};
            out_err_q   <= 1'b0;
            out_cause_q <= LSU_CAUSE_OK;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_cause_q <= out_cause_d;
        end
    end

    assign in_ready  = idle_s;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign out_cause = out_cause_q;

    assign araddr  = addr_q[AXI_ADDR_W-1:0];
    assign arvalid = (state_q == ST_AR);
    assign rready  = (state_q == ST_R);
    assign awaddr  = addr_q[AXI_ADDR_W-1:0];
    // Each channel's VALID drops once its own handshake is recorded.
    assign awvalid = (state_q == ST_AW_W) && !aw_done_q;
    assign wvalid  = (state_q == ST_AW_W) && !w_done_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign bready  = (state_q == ST_B);

endmodule

// File: tb/tb_lsu_axi.sv
module tb_lsu_axi;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // XLEN=32, trapping instance
    logic        in_valid, in_ready, in_unsigned, out_valid, out_ready, out_err;
    logic [1:0]  in_op, in_size, out_cause, rresp, bresp;
    logic [31:0] in_addr, in_wdata, in_wb_data, out_data;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;

    // XLEN=64, force-aligning instance
    logic        in_valid64, in_ready64, in_unsigned64, out_valid64, out_err64;
    logic [1:0]  in_op64, in_size64, out_cause64, rresp64, bresp64;
    logic [63:0] in_addr64, in_wdata64, in_wb_data64, out_data64, rdata64, wdata64;
    logic [31:0] araddr64, awaddr64;
    logic [7:0]  wstrb64;
    logic        arvalid64, arready64, rvalid64, rready64, awvalid64, awready64, wvalid64, wready64, bvalid64, bready64;

    lsu_axi #(.XLEN(32), .AXI_ADDR_W(32), .MISALIGN_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_wb_data(in_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .out_cause(out_cause),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    lsu_axi #(.XLEN(64), .AXI_ADDR_W(32), .MISALIGN_TRAP(1'b0)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_op(in_op64), .in_size(in_size64),
        .in_unsigned(in_unsigned64), .in_addr(in_addr64), .in_wdata(in_wdata64), .in_wb_data(in_wb_data64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64), .out_err(out_err64),
        .out_cause(out_cause64),
        .araddr(araddr64), .arvalid(arvalid64), .arready(arready64),
        .rdata(rdata64), .rresp(rresp64), .rvalid(rvalid64), .rready(rready64),
        .awaddr(awaddr64), .awvalid(awvalid64), .awready(awready64),
        .wdata(wdata64), .wstrb(wstrb64), .wvalid(wvalid64), .wready(wready64),
        .bresp(bresp64), .bvalid(bvalid64), .bready(bready64)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int ar_cnt  = 0;
    int ar_before;

    // Counts cycles with arvalid high on the 32-bit instance.
    always @(posedge clk) begin
        if (arvalid) ar_cnt <= ar_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] wb);
        in_valid = 1'b1; in_op = op; in_size = size; in_unsigned = uns;
        in_addr = addr; in_wdata = wd; in_wb_data = wb;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic issue64(input logic [1:0] op, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr);
        in_valid64 = 1'b1; in_op64 = op; in_size64 = size; in_unsigned64 = uns;
        in_addr64 = addr; in_wdata64 = 64'h0; in_wb_data64 = 64'h0;
        tick;
        in_valid64 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_op = 2'b00; in_size = 2'b00; in_unsigned = 1'b0;
        in_addr = 32'h0; in_wdata = 32'h0; in_wb_data = 32'h0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        in_valid64 = 1'b0; in_op64 = 2'b00; in_size64 = 2'b00; in_unsigned64 = 1'b0;
        in_addr64 = 64'h0; in_wdata64 = 64'h0; in_wb_data64 = 64'h0;
        arready64 = 1'b0; rvalid64 = 1'b0; rdata64 = 64'h0; rresp64 = 2'b00;
        awready64 = 1'b0; wready64 = 1'b0; bvalid64 = 1'b0; bresp64 = 2'b00;
        tick; tick;
        rst = 1'b0;
        tick;

        // Reset state
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_valids", {arvalid, rready, awvalid, wvalid, bready, out_valid}, 0);
        check_eq("rst_out", {out_err, out_cause, out_data}, 0);
        check_eq("rst_in_ready64", in_ready64, 1);

        // LB at 0x8000_0003, sign-extended top byte, minimum latency
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h80FF_FF00; rresp = 2'b00;
        issue(LSU_OP_LOAD, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h0);
        check_eq("lb_arvalid_c1", arvalid, 1);
        check_eq("lb_araddr", araddr, 32'h8000_0003);
        check_eq("lb_no_out_c1", out_valid, 0);
        tick;
        check_eq("lb_rready_c2", rready, 1);
        check_eq("lb_no_out_c2", out_valid, 0);
        tick;
        check_eq("lb_out_valid_c3", out_valid, 1);
        check_eq("lb_data", out_data, 32'hFFFF_FF80);
        check_eq("lb_err", {out_err, out_cause}, 0);
        tick;
        check_eq("lb_in_ready_after", in_ready, 1);
        arready = 1'b0; rvalid = 1'b0;

        // SH 0xBEEF at 0x2, awready late, wready immediate
        wready = 1'b1; awready = 1'b0; bvalid = 1'b0;
        issue(LSU_OP_STORE, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_BEEF, 32'h0);
        check_eq("sh_aw_w_c1", {awvalid, wvalid}, 2'b11);
        check_eq("sh_wstrb", wstrb, 4'b1100);
        check_eq("sh_wdata", wdata, 32'hBEEF_0000);
        check_eq("sh_awaddr", awaddr, 32'h0000_0002);
        tick;
        check_eq("sh_w_dropped", {awvalid, wvalid}, 2'b10);
        tick; tick;
        check_eq("sh_aw_hold", {awvalid, awaddr}, {1'b1, 32'h0000_0002});
        check_eq("sh_w_stable", {wstrb, wdata}, {4'b1100, 32'hBEEF_0000});
        awready = 1'b1;
        tick;
        awready = 1'b0;
        check_eq("sh_b_phase", {bready, awvalid, out_valid}, 3'b100);
        tick;
        check_eq("sh_wait_b", out_valid, 0);
        bvalid = 1'b1;
        tick;
        bvalid = 1'b0;
        check_eq("sh_out_valid", out_valid, 1);
        check_eq("sh_err", {out_err, out_cause}, 0);
        tick;
        wready = 1'b0;

        // LW at 0x1001 faults as misaligned, no bus traffic
        ar_before = ar_cnt;
        issue(LSU_OP_LOAD, 2'd2, 1'b0, 32'h0000_1001, 32'h0, 32'h0);
        check_eq("mis_out_valid_c1", out_valid, 1);
        check_eq("mis_err_cause", {out_err, out_cause}, {1'b1, LSU_CAUSE_MISALIGN});
        check_eq("mis_no_ar", arvalid, 0);
        tick;
        check_eq("mis_no_ar_cycles", ar_cnt, ar_before);

        // LD with XLEN=32 is an illegal size
        issue(LSU_OP_LOAD, 2'd3, 1'b0, 32'h0000_0008, 32'h0, 32'h0);
        check_eq("ill_out_valid", out_valid, 1);
        check_eq("ill_err_cause", {out_err, out_cause}, {1'b1, LSU_CAUSE_ILLEGAL_SIZE});
        check_eq("ill_no_ar", arvalid, 0);
        tick;

        // XLEN=64: LD at 0x8 returns the full word
        arready64 = 1'b1; rvalid64 = 1'b1; rdata64 = 64'h1234_5678_9ABC_DEF0;
        issue64(LSU_OP_LOAD, 2'd3, 1'b0, 64'h8);
        check_eq("ld64_araddr", araddr64, 32'h0000_0008);
        tick; tick;
        check_eq("ld64_out_valid", out_valid64, 1);
        check_eq("ld64_data", out_data64, 64'h1234_5678_9ABC_DEF0);
        tick;

        // XLEN=64 force-align: LW at 0x1006 issued at 0x1004, upper word
        rdata64 = 64'h1122_3344_5566_7788;
        issue64(LSU_OP_LOAD, 2'd2, 1'b0, 64'h1006);
        check_eq("lw64_align_addr", araddr64, 32'h0000_1004);
        tick; tick;
        check_eq("lw64_data", {out_valid64, out_err64, out_data64}, {1'b1, 1'b0, 64'h0000_0000_1122_3344});
        tick;

        // XLEN=64 LBU at 0xF, top lane, zero-extended
        rdata64 = 64'hAB00_0000_0000_0000;
        issue64(LSU_OP_LOAD, 2'd0, 1'b1, 64'hF);
        tick; tick;
        check_eq("lbu64_data", out_data64, 64'h0000_0000_0000_00AB);
        tick;
        arready64 = 1'b0; rvalid64 = 1'b0;

        // LW with SLVERR, WB stalls for 5 cycles
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        out_ready = 1'b0;
        issue(LSU_OP_LOAD, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        tick; tick;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            check_eq("bus_hold_out", {out_valid, out_err, out_cause, out_data},
                     {1'b1, 1'b1, LSU_CAUSE_BUS, 32'hDEAD_BEEF});
            check_eq("bus_hold_in_ready", in_ready, 0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        check_eq("bus_release", {in_ready, out_valid}, 2'b10);

        // Reset while in R with rvalid pending
        arready = 1'b1; rvalid = 1'b0;
        issue(LSU_OP_LOAD, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 32'h0);
        tick;
        check_eq("rr_in_r", rready, 1);
        rvalid = 1'b1; rst = 1'b1;
        tick;
        rst = 1'b0;
        check_eq("rr_after_rst", {rready, out_valid, in_ready, arvalid}, 4'b0010);
        tick;
        check_eq("rr_late_rvalid", {out_valid, in_ready}, 2'b01);
        rvalid = 1'b0; arready = 1'b0;
        issue(LSU_OP_NONE, 2'd0, 1'b0, 32'h0, 32'h0, 32'h1234_5678);
        check_eq("none_out", {out_valid, out_err, out_cause, out_data},
                 {1'b1, 1'b0, LSU_CAUSE_OK, 32'h1234_5678});
        tick;
        check_eq("none_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
